// File: rtl/coll_event_gen.sv
// coll_event_gen: synchronizes and debounces the raw good/bad collision inputs, queues the
// resulting events in small saturating counters, and issues spaced one-cycle strobes to the
// score logic. Bad events have strict priority over good ones.
// Optional feature macro: COLL_AUTOREPEAT_EN (periodic extra events while an input stays high).
module coll_event_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES      = 10,
   parameter int unsigned PEND_MAX        = 3,
   parameter int unsigned REPEAT_CYCLES   = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic goodBtnRaw,
   input  logic badBtnRaw,
   output logic goodCollButton,
   output logic badCollButton,
   output logic busy,
   output logic eventDropped
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
   localparam logic [CW-1:0] CntMax  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] GapLoad = GW'(GAP_CYCLES - 1);
   localparam logic [2:0]    PendMax = 3'(PEND_MAX);

   if (DEBOUNCE_CYCLES < 1 || GAP_CYCLES < 1 || PEND_MAX < 1 || PEND_MAX > 7 ||
       REPEAT_CYCLES < 1) begin : g_param_err
      $error("coll_event_gen: illegal parameter value");
   end

   typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

   // Index 0 is the good input, index 1 the bad input.
   logic [1:0]    raw;
   logic [1:0]    meta_q, sync_q;
   logic [1:0]    db_q, db_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    rise, ev;

   logic [2:0]    gp_q, gp_d, bp_q, bp_d;
   logic          drop_d, dropped_q, busy_q;
   logic          take_good, take_bad;

   state_e        state_q;
   logic [GW-1:0] gap_q;
   logic          good_q, bad_q;

   assign raw = {badBtnRaw, goodBtnRaw};

   // Two-flop synchronizers for the asynchronous raw inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
      end
   end

   // Debouncer next state: a level must persist DEBOUNCE_CYCLES samples to be accepted.
   always_comb begin
      db_d = db_q;
      rise = '0;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            db_d[i]  = sync_q[i];
            cnt_d[i] = '0;
            rise[i]  = sync_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         db_q <= db_d;
         for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef COLL_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [RW-1:0] RepMax = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q [2];
   logic [RW-1:0] rep_d [2];
   logic [1:0]    rep_ev;

   // Repeat timers run only while the debounced level is high, phased from the original event.
   always_comb begin
      rep_ev = '0;
      for (int i = 0; i < 2; i++) begin
         if (!db_q[i]) begin
            rep_d[i] = '0;
         end else if (rep_q[i] == RepMax) begin
            rep_d[i]  = '0;
            rep_ev[i] = 1'b1;
         end else begin
            rep_d[i] = rep_q[i] + RW'(1);
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) rep_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) rep_q[i] <= rep_d[i];
      end
   end

   assign ev = rise | rep_ev;
`else
   assign ev = rise;
`endif

   // Strobe selection from IDLE; bad wins whenever both are pending.
   always_comb begin
      take_bad  = (state_q == StIdle) && (bp_q != '0);
      take_good = (state_q == StIdle) && (bp_q == '0) && (gp_q != '0);
   end

   // Pending counters: a simultaneous event and dispatch cancel out; a full counter drops.
   always_comb begin
      gp_d   = gp_q;
      bp_d   = bp_q;
      drop_d = 1'b0;
      if (ev[0] && !take_good) begin
         if (gp_q == PendMax) drop_d = 1'b1;
         else                 gp_d   = gp_q + 3'd1;
      end else if (!ev[0] && take_good) begin
         gp_d = gp_q - 3'd1;
      end
      if (ev[1] && !take_bad) begin
         if (bp_q == PendMax) drop_d = 1'b1;
         else                 bp_d   = bp_q + 3'd1;
      end else if (!ev[1] && take_bad) begin
         bp_d = bp_q - 3'd1;
      end
   end

   // Pending counters, sticky drop flag and busy status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gp_q      <= '0;
         bp_q      <= '0;
         dropped_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         gp_q      <= gp_d;
         bp_q      <= bp_d;
         dropped_q <= dropped_q | drop_d;
         busy_q    <= (state_q != StIdle) || (gp_q != '0) || (bp_q != '0);
      end
   end

   // Strobe sequencer: one-cycle pulse, then GAP_CYCLES+1 cycles before IDLE may fire again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         gap_q   <= '0;
         good_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         good_q <= 1'b0;
         bad_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (take_bad) begin
                  bad_q   <= 1'b1;
                  state_q <= StPulse;
               end else if (take_good) begin
                  good_q  <= 1'b1;
                  state_q <= StPulse;
               end
            end
            StPulse: begin
               gap_q   <= GapLoad;
               state_q <= StGap;
            end
            StGap: begin
               if (gap_q == '0) state_q <= StIdle;
               else             gap_q   <= gap_q - GW'(1);
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign goodCollButton = good_q;
   assign badCollButton  = bad_q;
   assign busy           = busy_q;
   assign eventDropped   = dropped_q;

endmodule

// File: tb/tb_coll_event_gen.sv
// Directed bench for coll_event_gen with default parameters. Time advances only through
// step(), which samples the outputs 1 time unit after each rising edge and logs strobe cycles.
module tb_coll_event_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic goodBtnRaw = 1'b0;
   logic badBtnRaw = 1'b0;
   logic goodCollButton, badCollButton, busy, eventDropped;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int overlap = 0;
   int good_t[$];
   int bad_t[$];

   always #5 clk = ~clk;

   coll_event_gen dut (
      .clk            (clk),
      .rst            (rst),
      .goodBtnRaw     (goodBtnRaw),
      .badBtnRaw      (badBtnRaw),
      .goodCollButton (goodCollButton),
      .badCollButton  (badCollButton),
      .busy           (busy),
      .eventDropped   (eventDropped)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         if (goodCollButton === 1'b1) good_t.push_back(cyc);
         if (badCollButton === 1'b1) bad_t.push_back(cyc);
         if (goodCollButton === 1'b1 && badCollButton === 1'b1) overlap++;
      end
   endtask

   task automatic clear_log();
      good_t.delete();
      bad_t.delete();
   endtask

   task automatic test_reset();
      logic [3:0] outs;
      for (int i = 0; i < 2; i++) begin
         goodBtnRaw = ~goodBtnRaw;
         badBtnRaw  = ~badBtnRaw;
         step(1);
         outs = {goodCollButton, badCollButton, busy, eventDropped};
         checks++;
         if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", outs);
         end
      end
      goodBtnRaw = 1'b0;
      badBtnRaw  = 1'b0;
      rst = 1'b1;
      clear_log();
      step(50);
      checks++;
      if (good_t.size() + bad_t.size() != 0) begin
         errors++;
         $display("FAIL reset_idle_strobes: got %0d expected 0", good_t.size() + bad_t.size());
      end
      checks++;
      if ({busy, eventDropped} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle_status: got %b expected 00", {busy, eventDropped});
      end
   endtask

   task automatic test_single();
      int t0, got;
      clear_log();
      t0 = cyc;
      goodBtnRaw = 1'b1;
      step(20);
      goodBtnRaw = 1'b0;
      step(30);
      checks++;
      if (good_t.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d expected 1", good_t.size());
      end
      got = (good_t.size() > 0) ? good_t[0] - t0 : -1;
      checks++;
      if (got != 7) begin
         errors++;
         $display("FAIL single_latency: got %0d expected 7", got);
      end
      checks++;
      if (bad_t.size() != 0) begin
         errors++;
         $display("FAIL single_no_bad: got %0d expected 0", bad_t.size());
      end
   endtask

   task automatic test_bounce();
      int t1, got;
      clear_log();
      for (int i = 0; i < 2; i++) begin
         goodBtnRaw = 1'b1;
         step(2);
         goodBtnRaw = 1'b0;
         step(2);
      end
      t1 = cyc;
      goodBtnRaw = 1'b1;
      step(20);
      goodBtnRaw = 1'b0;
      step(30);
      checks++;
      if (good_t.size() != 1) begin
         errors++;
         $display("FAIL bounce_count: got %0d expected 1", good_t.size());
      end
      got = (good_t.size() > 0) ? good_t[0] - t1 : -1;
      checks++;
      if (got != 7) begin
         errors++;
         $display("FAIL bounce_latency: got %0d expected 7", got);
      end
   endtask

   task automatic test_simultaneous();
      int t0, got;
      clear_log();
      t0 = cyc;
      goodBtnRaw = 1'b1;
      badBtnRaw  = 1'b1;
      step(20);
      goodBtnRaw = 1'b0;
      badBtnRaw  = 1'b0;
      step(5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL simul_busy_gap: got %b expected 1", busy);
      end
      step(25);
      got = (bad_t.size() == 1) ? bad_t[0] - t0 : -1;
      checks++;
      if (got != 7) begin
         errors++;
         $display("FAIL simul_bad_first: got %0d expected 7", got);
      end
      got = (good_t.size() == 1) ? good_t[0] - t0 : -1;
      checks++;
      if (got != 19) begin
         errors++;
         $display("FAIL simul_good_second: got %0d expected 19", got);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL simul_busy_end: got %b expected 0", busy);
      end
   endtask

   // A good event is issued at once; four more good events arrive alongside bad events,
   // which take every dispatch slot, so the good queue fills to 3 and the fourth is dropped.
   task automatic test_saturation();
      int t0, got;
      int exp_g[4] = '{7, 67, 79, 91};
      int exp_b[4] = '{19, 31, 43, 55};
      clear_log();
      t0 = cyc;
      goodBtnRaw = 1'b1;
      step(6);
      goodBtnRaw = 1'b0;
      step(6);
      for (int k = 0; k < 4; k++) begin
         goodBtnRaw = 1'b1;
         badBtnRaw  = 1'b1;
         step(6);
         goodBtnRaw = 1'b0;
         badBtnRaw  = 1'b0;
         step(6);
      end
      step(50);
      checks++;
      if (good_t.size() != 4 || bad_t.size() != 4) begin
         errors++;
         $display("FAIL sat_counts: got good %0d bad %0d expected good 4 bad 4",
                  good_t.size(), bad_t.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < good_t.size()) ? good_t[i] - t0 : -1;
         checks++;
         if (got != exp_g[i]) begin
            errors++;
            $display("FAIL sat_good_time[%0d]: got %0d expected %0d", i, got, exp_g[i]);
         end
         got = (i < bad_t.size()) ? bad_t[i] - t0 : -1;
         checks++;
         if (got != exp_b[i]) begin
            errors++;
            $display("FAIL sat_bad_time[%0d]: got %0d expected %0d", i, got, exp_b[i]);
         end
      end
      checks++;
      if (eventDropped !== 1'b1) begin
         errors++;
         $display("FAIL sat_dropped: got %b expected 1", eventDropped);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL sat_busy_end: got %b expected 0", busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (eventDropped !== 1'b0) begin
         errors++;
         $display("FAIL sat_dropped_reset: got %b expected 0", eventDropped);
      end
      step(2);
      rst = 1'b1;
      step(5);
   endtask

   task automatic test_reset_mid();
      int t0, tr, got;
      clear_log();
      t0 = cyc;
      goodBtnRaw = 1'b1;
      step(7);
      checks++;
      if (goodCollButton !== 1'b1) begin
         errors++;
         $display("FAIL midrst_strobe_before: got %b expected 1", goodCollButton);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({goodCollButton, busy} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_cut: got %b expected 00", {goodCollButton, busy});
      end
      step(2);
      clear_log();
      tr = cyc;
      rst = 1'b1;
      step(20);
      goodBtnRaw = 1'b0;
      step(30);
      got = (good_t.size() == 1) ? good_t[0] - tr : -1;
      checks++;
      if (got != 7) begin
         errors++;
         $display("FAIL midrst_held_event: got %0d expected 7 (count %0d)", got, good_t.size());
      end
      if (t0 < 0) $display("unreachable");
   endtask

   task automatic test_autorepeat();
      int t0, got;
`ifdef COLL_AUTOREPEAT_EN
      int exp_g[4] = '{7, 57, 107, 157};
      int n_exp = 4;
`else
      int exp_g[4] = '{7, 0, 0, 0};
      int n_exp = 1;
`endif
      clear_log();
      t0 = cyc;
      goodBtnRaw = 1'b1;
      step(160);
      goodBtnRaw = 1'b0;
      step(40);
      checks++;
      if (good_t.size() != n_exp) begin
         errors++;
         $display("FAIL repeat_count: got %0d expected %0d", good_t.size(), n_exp);
      end
      for (int i = 0; i < n_exp; i++) begin
         got = (i < good_t.size()) ? good_t[i] - t0 : -1;
         checks++;
         if (got != exp_g[i]) begin
            errors++;
            $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, got, exp_g[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounce();
      test_simultaneous();
      test_saturation();
      test_reset_mid();
      test_autorepeat();
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL strobe_overlap: got %0d expected 0", overlap);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
